vga_wb_arbiter_n: RTL and testbench
===================================

VGA_WB_ARBITER_N -- requirements
Module: vga_wb_arbiter_n

Interface
REQ-001 SHALL have parameter NCH, default 2: number of request channels, legal 2..8.
REQ-002 SHALL have parameter BCNT_W, default 4: burst-counter width.
REQ-003 SHALL have parameter RR, default 0: arbitration mode, 0 = fixed priority, 1 = round-robin.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port nrst_i  input  1  asynchronous active-low reset.
REQ-006 SHALL have port sclr_i  input  1  synchronous clear, active high.
REQ-007 SHALL have port req_i  input  NCH  per-channel access request, level.
REQ-008 SHALL have port abort_i  input  NCH  per-channel abort (frame done, cursor done).
REQ-009 SHALL have port blen_i  input  NCH*BCNT_W  per-channel burst length minus 1; channel k in bits [k*BCNT_W +: BCNT_W].
REQ-010 SHALL have port ack_i  input  1  Wishbone beat acknowledge.
REQ-011 SHALL have port gnt_o  output  NCH  registered one-hot grant.
REQ-012 SHALL have port busy_o  output  1  access in progress.
REQ-013 SHALL have port cnt_o  output  BCNT_W  beats remaining after the current beat.
REQ-014 SHALL have port last_o  output  1  current beat is final beat of burst.
REQ-015 SHALL have port done_o  output  NCH  one-cycle pulse on normal burst completion.

Function
REQ-016 SHALL implement two states: IDLE (gnt_o = 0) and XFER (exactly one gnt_o bit set).
REQ-017 SHALL hold gnt_o one-hot-or-zero and busy_o == |gnt_o in every cycle, including cycles with X-free inputs only.
REQ-018 SHALL compute eligible = req_i & ~abort_i; a channel with abort_i high in the arbitration cycle SHALL NOT be granted.
REQ-019 SHALL, in IDLE with any eligible bit set at edge N, assert gnt_o[w] from edge N+1 (1-cycle latency) and load cnt_o with blen_i[w] sampled at edge N.
REQ-020 SHALL, with RR=0, choose w as the lowest-index eligible channel.
REQ-021 SHALL, with RR=1, choose w as the first eligible channel searching upward (modulo NCH) from last-granted+1; last-granted pointer resets to NCH-1 so channel 0 wins first.
REQ-022 SHALL, in XFER, on ack_i with cnt_o != 0, decrement cnt_o by 1 and keep the grant.
REQ-023 SHALL drive last_o = busy_o & (cnt_o == 0).
REQ-024 SHALL, in XFER, on ack_i with cnt_o == 0, pulse done_o[g] for the same cycle as that ack (combinational on ack_i & last_o) and release the grant at the next edge.
REQ-025 SHALL re-arbitrate in the completion cycle: if any channel is eligible then, the winner's grant SHALL start at the next edge (zero-bubble back-to-back); otherwise return to IDLE.
REQ-026 SHALL, when abort_i[g] is high for the granted channel g, release the grant at the next edge, suppress done_o[g], and not re-arbitrate that cycle; abort dominates a simultaneous final ack.
REQ-027 SHALL ignore abort_i of non-granted channels in XFER.
REQ-028 SHALL ignore req_i deassertion during XFER; a burst ends only by final ack, abort, sclr_i or reset.
REQ-029 SHALL ignore ack_i in IDLE (no counter change, no done_o).
REQ-030 SHALL treat blen_i = 0 as a single-beat burst (last_o high from grant cycle).
REQ-031 SHALL update the RR pointer only when a new grant is issued, never on abort.

Reset
REQ-032 SHALL, on nrst_i low, immediately (asynchronously) force gnt_o = 0, busy_o = 0, cnt_o = 0, last_o = 0, done_o = 0, state IDLE, RR pointer NCH-1.
REQ-033 SHALL, on sclr_i high at an edge, apply the reset values of REQ-032 at that edge; sclr_i dominates all other inputs, including a simultaneous request.
REQ-034 SHALL, on reset or sclr_i mid-burst, drop the grant without done_o pulse.

Verification
REQ-035 SHALL cover: NCH=2, RR=0, req_i=11, blen=3 both -> gnt_o=01 next cycle, done_o[0] on 4th ack, gnt_o=10 the following cycle.
REQ-036 SHALL cover: NCH=4, RR=1, req_i=1111 held, blen=0 -> grants 0001,0010,0100,1000,0001 on consecutive acked cycles.
REQ-037 SHALL cover: burst on ch0 blen=5, abort_i[0] after 2 acks -> gnt_o=0 next cycle, done_o never pulses, cnt_o=0.
REQ-038 SHALL cover: final ack and abort_i[g] same cycle -> no done_o, grant released, no new grant that cycle.
REQ-039 SHALL cover: nrst_i low mid-burst between edges -> all outputs 0 immediately; sclr_i with req_i=01 -> gnt_o stays 0.
REQ-040 SHALL cover: ack_i pulses in IDLE -> cnt_o, done_o, gnt_o unchanged; assertion busy_o == |gnt_o holds throughout.

Source files
------------

// File: rtl/vga_wb_arbiter_n.sv
// rtl/vga_wb_arbiter_n.sv - N-channel Wishbone burst arbiter for VGA fetch engines
//
// Ports:
//   clk_i    sole clock, rising edge
//   nrst_i   asynchronous active-low reset
//   sclr_i   synchronous clear, active high, dominates all other inputs
//   req_i    per-channel level request
//   abort_i  per-channel abort; only the granted channel's bit matters in XFER
//   blen_i   per-channel burst length minus 1, channel k at [k*BCNT_W +: BCNT_W]
//   ack_i    Wishbone beat acknowledge
//   gnt_o    registered one-hot grant
//   busy_o   access in progress (|gnt_o)
//   cnt_o    beats remaining after the current beat
//   last_o   current beat is the final beat of the burst
//   done_o   one-cycle pulse, same cycle as the final ack of a normal completion

module vga_wb_arbiter_n #(
  parameter int NCH    = 2,
  parameter int BCNT_W = 4,
  parameter int RR     = 0
) (
  input  logic                  clk_i,
  input  logic                  nrst_i,
  input  logic                  sclr_i,
  input  logic [NCH-1:0]        req_i,
  input  logic [NCH-1:0]        abort_i,
  input  logic [NCH*BCNT_W-1:0] blen_i,
  input  logic                  ack_i,
  output logic [NCH-1:0]        gnt_o,
  output logic                  busy_o,
  output logic [BCNT_W-1:0]     cnt_o,
  output logic                  last_o,
  output logic [NCH-1:0]        done_o
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_XFER = 1'b1;

  logic              state_q, state_d;
  logic [NCH-1:0]    gnt_q, gnt_d;
  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;

  logic [NCH-1:0]    eligible;
  logic              own_abort;
  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic              grant_new;
  int                cand;

  assign eligible  = req_i & ~abort_i;
  // Only the granted channel's abort matters; others are ignored in XFER.
  assign own_abort = |(gnt_q & abort_i);

  assign gnt_o  = gnt_q;
  assign busy_o = |gnt_q;
  assign cnt_o  = cnt_q;
  assign last_o = busy_o & (cnt_q == '0);
  // Abort dominates a simultaneous final ack, so no completion pulse then.
  assign done_o = (ack_i && last_o && !own_abort) ? gnt_q : '0;

  // Winner search: fixed priority scans upward from 0, round-robin scans
  // upward from one past the last granted channel, wrapping at NCH.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NCH; i++) begin
      if (RR != 0) begin
        cand = int'(ptr_q) + 1 + i;
        if (cand >= NCH) cand = cand - NCH;
      end else begin
        cand = i;
      end
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    grant_new = 1'b0;

    if (state_q == ST_IDLE) begin
      grant_new = win_found;
    end else begin
      if (own_abort) begin
        // Abort: release without completion and without re-arbitrating.
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end else if (ack_i) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - BCNT_W'(1);
        end else if (win_found) begin
          // Back-to-back: next winner takes over at the very next edge.
          grant_new = 1'b1;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
    end

    if (grant_new) begin
      state_d = ST_XFER;
      gnt_d   = {{(NCH-1){1'b0}}, 1'b1} << win_idx;
      cnt_d   = blen_i[win_idx*BCNT_W +: BCNT_W];
      ptr_d   = win_idx;
    end

    if (sclr_i) begin
      state_d = ST_IDLE;
      gnt_d   = '0;
      cnt_d   = '0;
      ptr_d   = PW'(NCH - 1);
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= PW'(NCH - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_vga_wb_arbiter_n.sv
// tb/tb_vga_wb_arbiter_n.sv - scoreboard bench for vga_wb_arbiter_n (NCH=2 fixed, NCH=4 round-robin)

module tb_vga_wb_arbiter_n;

  typedef struct {
    int         d;
    logic [7:0] gnt;
    logic [7:0] done;
    logic [3:0] cnt;
    logic       last;
  } exp_t;

  localparam int NCHV [2] = '{2, 4};
  localparam int RRV  [2] = '{0, 1};

  logic clk;
  logic nrst;
  logic [7:0] req_v   [2];
  logic [7:0] abort_v [2];
  logic [3:0] blen_v  [2][8];
  logic       ack_v   [2];
  logic       sclr_v  [2];

  logic [1:0] gnt0, done0;
  logic [3:0] gnt1, done1;
  logic [3:0] cnt0, cnt1;
  logic       busy0, busy1, last0, last1;

  int owner [2];
  int rem   [2];
  int lg    [2];

  exp_t sbq[$];
  int   checks;
  int   passes;

  vga_wb_arbiter_n #(.NCH(2), .BCNT_W(4), .RR(0)) dut0 (
    .clk_i  (clk),
    .nrst_i (nrst),
    .sclr_i (sclr_v[0]),
    .req_i  (req_v[0][1:0]),
    .abort_i(abort_v[0][1:0]),
    .blen_i ({blen_v[0][1], blen_v[0][0]}),
    .ack_i  (ack_v[0]),
    .gnt_o  (gnt0),
    .busy_o (busy0),
    .cnt_o  (cnt0),
    .last_o (last0),
    .done_o (done0)
  );

  vga_wb_arbiter_n #(.NCH(4), .BCNT_W(4), .RR(1)) dut1 (
    .clk_i  (clk),
    .nrst_i (nrst),
    .sclr_i (sclr_v[1]),
    .req_i  (req_v[1][3:0]),
    .abort_i(abort_v[1][3:0]),
    .blen_i ({blen_v[1][3], blen_v[1][2], blen_v[1][1], blen_v[1][0]}),
    .ack_i  (ack_v[1]),
    .gnt_o  (gnt1),
    .busy_o (busy1),
    .cnt_o  (cnt1),
    .last_o (last1),
    .done_o (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act == exp_v) passes++;
    else $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      owner[d] = -1;
      rem[d]   = 0;
      lg[d]    = NCHV[d] - 1;
    end
  endtask

  function automatic int pick(input int d, input logic [7:0] el);
    int w;
    int c;
    w = -1;
    for (int k = 1; k <= NCHV[d]; k++) begin
      c = (RRV[d] != 0) ? (lg[d] + k) % NCHV[d] : k - 1;
      if (w < 0 && el[c]) w = c;
    end
    return w;
  endfunction

  task automatic start_grant(input int d, input logic [7:0] el);
    int w;
    w = pick(d, el);
    owner[d] = w;
    if (w >= 0) begin
      rem[d] = int'(blen_v[d][w]);
      lg[d]  = w;
    end
  endtask

  // Expected outputs for the current cycle, then advance the model across the edge.
  task automatic model_cycle(input int d);
    exp_t       e;
    logic [7:0] el;
    logic [7:0] mask;
    mask   = 8'((1 << NCHV[d]) - 1);
    el     = req_v[d] & ~abort_v[d] & mask;
    e.d    = d;
    e.gnt  = (owner[d] >= 0) ? 8'(1 << owner[d]) : 8'd0;
    e.cnt  = 4'(rem[d]);
    e.last = (owner[d] >= 0) && (rem[d] == 0);
    e.done = (owner[d] >= 0 && ack_v[d] && rem[d] == 0 && !abort_v[d][owner[d]]) ? e.gnt : 8'd0;
    sbq.push_back(e);

    if (sclr_v[d]) begin
      owner[d] = -1;
      rem[d]   = 0;
      lg[d]    = NCHV[d] - 1;
    end else if (owner[d] < 0) begin
      start_grant(d, el);
    end else if (abort_v[d][owner[d]]) begin
      owner[d] = -1;
      rem[d]   = 0;
    end else if (ack_v[d]) begin
      if (rem[d] > 0) rem[d] = rem[d] - 1;
      else start_grant(d, el);
    end
  endtask

  task automatic cycle();
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs(input int d);
    req_v[d]   = '0;
    abort_v[d] = '0;
    ack_v[d]   = 1'b0;
    sclr_v[d]  = 1'b0;
    for (int k = 0; k < 8; k++) blen_v[d][k] = '0;
  endtask

  // Monitor: pops the expectations pushed for this cycle and compares mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    int ag, ad, ac, al, ab;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.d == 0) begin
        ag = int'(gnt0); ad = int'(done0); ac = int'(cnt0); al = int'(last0); ab = int'(busy0);
      end else begin
        ag = int'(gnt1); ad = int'(done1); ac = int'(cnt1); al = int'(last1); ab = int'(busy1);
      end
      chk($sformatf("dut%0d_gnt t=%0t", e.d, $time), ag, int'(e.gnt));
      chk($sformatf("dut%0d_done t=%0t", e.d, $time), ad, int'(e.done));
      chk($sformatf("dut%0d_cnt t=%0t", e.d, $time), ac, int'(e.cnt));
      chk($sformatf("dut%0d_last t=%0t", e.d, $time), al, int'(e.last));
      chk($sformatf("dut%0d_busy t=%0t", e.d, $time), ab, int'(e.gnt != 8'd0));
    end
    assert (busy0 == |gnt0 && busy1 == |gnt1 && $onehot0(gnt0) && $onehot0(gnt1));
  end

  initial begin
    checks = 0;
    passes = 0;
    nrst   = 1'b0;
    idle_inputs(0);
    idle_inputs(1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    chk("reset_gnt0", int'(gnt0), 0);
    chk("reset_gnt1", int'(gnt1), 0);
    chk("reset_cnt0", int'(cnt0), 0);
    chk("reset_busy1", int'(busy1), 0);

    // Fixed priority, both requesting blen=3; ch0 drops req mid-burst so ch1 follows.
    req_v[0] = 8'b11; blen_v[0][0] = 4'd3; blen_v[0][1] = 4'd3;
    // Round-robin, all requesting single beats with continuous ack.
    req_v[1] = 8'b1111; ack_v[1] = 1'b1;
    cycle();
    chk("fp_first_gnt", int'(gnt0), 1);
    ack_v[0] = 1'b1; req_v[0] = 8'b10;
    repeat (4) cycle();
    chk("fp_next_gnt", int'(gnt0), 2);
    repeat (3) cycle();
    req_v[0] = '0;
    cycle();
    chk("fp_idle_after", int'(gnt0), 0);
    idle_inputs(1);
    cycle();

    // Abort after two acks on a 6-beat burst.
    req_v[0] = 8'b01; blen_v[0][0] = 4'd5; ack_v[0] = 1'b0;
    cycle();
    ack_v[0] = 1'b1;
    repeat (2) cycle();
    ack_v[0] = 1'b0; abort_v[0] = 8'b01;
    cycle();
    chk("abort_gnt", int'(gnt0), 0);
    chk("abort_cnt", int'(cnt0), 0);
    abort_v[0] = '0; req_v[0] = '0;
    cycle();

    // Final ack coincides with abort while ch1 is eligible: no done, no new grant.
    req_v[0] = 8'b01; blen_v[0][0] = 4'd0;
    cycle();
    req_v[0] = 8'b11; ack_v[0] = 1'b1; abort_v[0] = 8'b01;
    cycle();
    chk("ack_abort_gnt", int'(gnt0), 0);
    req_v[0] = '0; ack_v[0] = 1'b0; abort_v[0] = '0;
    cycle();

    // Acks while idle change nothing.
    ack_v[0] = 1'b1; ack_v[1] = 1'b1;
    repeat (3) cycle();
    ack_v[0] = 1'b0; ack_v[1] = 1'b0;

    // Asynchronous reset asserted between edges mid-burst.
    req_v[0] = 8'b01; blen_v[0][0] = 4'd7;
    cycle();
    ack_v[0] = 1'b1;
    cycle();
    nrst = 1'b0;
    #2;
    chk("areset_gnt0", int'(gnt0), 0);
    chk("areset_cnt0", int'(cnt0), 0);
    chk("areset_busy0", int'(busy0), 0);
    chk("areset_last0", int'(last0), 0);
    chk("areset_done0", int'(done0), 0);
    model_reset();
    idle_inputs(0);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // Synchronous clear dominates a simultaneous request.
    req_v[0] = 8'b01; sclr_v[0] = 1'b1;
    cycle();
    chk("sclr_gnt0", int'(gnt0), 0);
    req_v[0] = '0; sclr_v[0] = 1'b0;
    cycle();

    // Randomized traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        req_v[d] = 8'($urandom_range(0, 255));
        for (int k = 0; k < 8; k++) begin
          abort_v[d][k] = ($urandom_range(0, 11) == 0);
          blen_v[d][k]  = 4'($urandom_range(0, 3));
        end
        ack_v[d]  = ($urandom_range(0, 9) < 7);
        sclr_v[d] = ($urandom_range(0, 49) == 0);
      end
      cycle();
    end
    idle_inputs(0);
    idle_inputs(1);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
